// File: rtl/axis_width_pkg.sv
// Shared helpers for the AXI-Stream width converters (upsizer and downsizer).
package axis_width_pkg;

    // Smallest ratio either converter can be built with.
    localparam int unsigned MIN_DATA_RATIO = 2;

    // Width of a lane index counter; never narrower than one bit.
    function automatic int unsigned lane_cnt_width(input int unsigned ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

    // True when a ratio can be elaborated.
    function automatic bit ratio_ok(input int unsigned ratio);
        return ratio >= MIN_DATA_RATIO;
    endfunction

endpackage

// File: rtl/axis_upsizer.sv
// Narrow-to-wide AXI-Stream converter: packs DATA_RATIO narrow beats
// little-endian into one wide word; tlast flushes a partial word.
module axis_upsizer
    import axis_width_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DATA_RATIO   = 8,
    parameter int unsigned S_DATA_WIDTH = DATA_WIDTH,
    parameter int unsigned M_DATA_WIDTH = DATA_RATIO * DATA_WIDTH
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [DATA_RATIO-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    localparam int unsigned LCW = lane_cnt_width(DATA_RATIO);

    if (!ratio_ok(DATA_RATIO)) begin : g_bad_ratio
        $error("axis_upsizer: DATA_RATIO must be at least 2");
    end

    logic [LCW-1:0]          lane_cnt_q, lane_cnt_d;
    logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [DATA_RATIO-1:0]   acc_keep_q, acc_keep_d;
    logic [M_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_RATIO-1:0]   out_keep_q, out_keep_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;

    logic                    s_ready;
    logic                    s_fire;
    logic                    m_fire;
    logic                    complete;
    logic [M_DATA_WIDTH-1:0] merged_data;
    logic [DATA_RATIO-1:0]   merged_keep;

    // Handshakes, lane merge and next-state for accumulator and output register.
    always_comb begin
        s_ready  = !out_valid_q || m_axis_tready;
        s_fire   = s_axis_tvalid && s_ready;
        m_fire   = out_valid_q && m_axis_tready;
        complete = (lane_cnt_q == LCW'(DATA_RATIO - 1)) || s_axis_tlast;

        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        for (int unsigned i = 0; i < DATA_RATIO; i++) begin
            if (lane_cnt_q == LCW'(i)) begin
                merged_data[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                merged_keep[i] = 1'b1;
            end
        end

        lane_cnt_d  = lane_cnt_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        // A drain clears valid; a completing beat in the same cycle overrides
        // it below so back-to-back words keep valid high.
        if (m_fire) begin
            out_valid_d = 1'b0;
        end

        if (s_fire) begin
            if (complete) begin
                out_data_d  = merged_data;
                out_keep_d  = merged_keep;
                out_last_d  = s_axis_tlast;
                out_valid_d = 1'b1;
                acc_data_d  = '0;
                acc_keep_d  = '0;
                lane_cnt_d  = '0;
            end else begin
                acc_data_d  = merged_data;
                acc_keep_d  = merged_keep;
                lane_cnt_d  = lane_cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lane_cnt_q  <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer with DATA_RATIO=4, DATA_WIDTH=8.
module tb_axis_upsizer;

    localparam int unsigned DW = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned MW = DW * R;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [MW-1:0] m_axis_tdata;
    logic [R-1:0]  m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;

    int tests = 0;
    int fails = 0;

    // Model state: beats gathered for the current word, and the expected output word.
    logic [DW-1:0] pend[$];
    logic          exp_valid = 1'b0;
    logic          exp_last = 1'b0;
    logic [MW-1:0] exp_data = '0;
    logic [R-1:0]  exp_keep = '0;

    axis_upsizer #(
        .DATA_WIDTH(DW),
        .DATA_RATIO(R)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
        exp_keep  = '0;
    endtask

    // Word-level model: collect accepted beats, emit a word when R are gathered or tlast seen.
    task automatic model_step();
        logic rdy;
        logic drained;
        if (areset) begin
            model_clear();
            return;
        end
        rdy     = !exp_valid || m_axis_tready;
        drained = exp_valid && m_axis_tready;
        if (drained) exp_valid = 1'b0;
        if (s_axis_tvalid && rdy) begin
            pend.push_back(s_axis_tdata);
            if (pend.size() == R || s_axis_tlast) begin
                exp_data = '0;
                exp_keep = '0;
                for (int i = 0; i < pend.size(); i++) begin
                    exp_data[i*DW +: DW] = pend[i];
                    exp_keep[i] = 1'b1;
                end
                exp_last  = s_axis_tlast;
                exp_valid = 1'b1;
                pend.delete();
            end
        end
    endtask

    // One clock: model advances on the rising edge, inputs may change just after the falling edge.
    task automatic cycle();
        @(posedge aclk);
        model_step();
        @(negedge aclk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        cycle();
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cycle();
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge aclk) begin
        check("s_tready", {63'd0, s_axis_tready}, {63'd0, (!exp_valid || m_axis_tready)});
        check("m_tvalid", {63'd0, m_axis_tvalid}, {63'd0, exp_valid});
        check("m_tdata",  {32'd0, m_axis_tdata},  {32'd0, exp_data});
        check("m_tkeep",  {60'd0, m_axis_tkeep},  {60'd0, exp_keep});
        check("m_tlast",  {63'd0, m_axis_tlast},  {63'd0, exp_last});
    end

    initial begin
        int cnt;
        model_clear();
        areset = 1'b1;
        cycle();
        cycle();
        check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tdata",  {32'd0, m_axis_tdata},  64'd0);
        areset = 1'b0;
        cycle();

        // 1: full word with tlast on the final lane.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        check("t1_data",  {32'd0, m_axis_tdata}, 64'h44332211);
        check("t1_keep",  {60'd0, m_axis_tkeep}, 64'hF);
        check("t1_last",  {63'd0, m_axis_tlast}, 64'd1);
        check("t1_valid", {63'd0, m_axis_tvalid}, 64'd1);
        idle();
        check("t1_valid_drop", {63'd0, m_axis_tvalid}, 64'd0);

        // 2: partial word, then a single-lane packet starting in lane 0.
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        check("t2_data", {32'd0, m_axis_tdata}, 64'h0000B2A1);
        check("t2_keep", {60'd0, m_axis_tkeep}, 64'h3);
        check("t2_last", {63'd0, m_axis_tlast}, 64'd1);
        send(8'h5A, 1'b1);
        check("t2_lane0_data", {32'd0, m_axis_tdata}, 64'h0000005A);
        check("t2_lane0_keep", {60'd0, m_axis_tkeep}, 64'h1);
        idle();

        // 3: backpressure holds the word and stalls the input.
        m_axis_tready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send(8'h66, 1'b0);
            check("t3_stall_ready", {63'd0, s_axis_tready}, 64'd0);
            check("t3_stall_data",  {32'd0, m_axis_tdata}, 64'h04030201);
            check("t3_stall_last",  {63'd0, m_axis_tlast}, 64'd0);
        end
        m_axis_tready = 1'b1;
        send(8'h66, 1'b0);
        check("t3_after_release_valid", {63'd0, m_axis_tvalid}, 64'd0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        send(8'h99, 1'b1);
        check("t3_resume_data", {32'd0, m_axis_tdata}, 64'h99887766);
        idle();

        // 4: streaming throughput, 32 beats -> 8 words.
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            send(DW'(i + 8'h40), 1'b0);
            if (m_axis_tvalid) cnt++;
            check("t4_ready", {63'd0, s_axis_tready}, 64'd1);
        end
        check("t4_words", 64'(cnt), 64'd8);
        check("t4_last_word", {32'd0, m_axis_tdata}, 64'h5F5E5D5C);
        idle();

        // 5: drain and load in the same cycle keeps valid high.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send(DW'(i + 8'hC0), 1'b1);
            if (m_axis_tvalid) cnt++;
        end
        check("t5_valid_cycles", 64'(cnt), 64'd8);
        check("t5_data", {32'd0, m_axis_tdata}, 64'h000000C7);
        idle();

        // 6: reset mid-packet discards the partial word.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        model_clear();
        cycle();
        check("t6_rst_valid", {63'd0, m_axis_tvalid}, 64'd0);
        check("t6_rst_keep",  {60'd0, m_axis_tkeep}, 64'd0);
        areset = 1'b0;
        cycle();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        check("t6_data", {32'd0, m_axis_tdata}, 64'h04030201);
        check("t6_keep", {60'd0, m_axis_tkeep}, 64'hF);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
